// File: rtl/dump_pkg.sv
// Shared types for the architectural register dump unit.
// Holds the default widths, the payload typedefs and the FSM state encoding.
package dump_pkg;

  localparam int DEF_NUM_ARCH_REGS = 32;
  localparam int DEF_AREG_W        = 5;
  localparam int DEF_PREG_W        = 7;
  localparam int DEF_XLEN          = 32;

  typedef logic [DEF_AREG_W-1:0] areg_t;
  typedef logic [DEF_PREG_W-1:0] preg_t;
  typedef logic [DEF_XLEN-1:0]   word_t;

  // CSUM is only reached when ARCH_DUMP_CHECKSUM_EN is defined.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    MAP   = 3'd2,
    READ  = 3'd3,
    SEND  = 3'd4,
    CSUM  = 3'd5,
    DONE  = 3'd6
  } dump_state_e;

endpackage

// File: rtl/arch_dump_beat_reg.sv
// Output beat holding register for the dump stream.
// Valid/ready rule: a beat is transferred on a cycle where out_valid && out_ready
// at the rising edge; while out_valid is high and out_ready is low, the payload
// and out_valid stay unchanged. A load takes priority over the clearing
// handshake, so a new beat can replace the one leaving in the same cycle.
module arch_dump_beat_reg #(
  parameter int AREG_W = 5,
  parameter int PREG_W = 7,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [AREG_W-1:0] in_areg,
  input  logic [PREG_W-1:0] in_preg,
  input  logic [XLEN-1:0]   in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AREG_W-1:0] out_areg,
  output logic [PREG_W-1:0] out_preg,
  output logic [XLEN-1:0]   out_data,
  output logic              out_last
);

  logic valid_q;
  logic last_q;

  // Capture a new beat on load; drop valid once the sink has taken the beat.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      out_areg <= '0;
      out_preg <= '0;
      out_data <= '0;
      last_q   <= 1'b0;
    end else if (load) begin
      valid_q  <= 1'b1;
      out_areg <= in_areg;
      out_preg <= in_preg;
      out_data <= in_data;
      last_q   <= in_last;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  // Last is qualified so a stale flag never shows outside a live beat.
  assign out_last  = valid_q & last_q;

endmodule

// File: rtl/arch_reg_dump_unit.sv
// Architectural register dump responder.
// Stalls fetch, waits for the ROB to drain, then walks x0..x(N-1) through the
// committed rename map and a PRF read port, emitting one beat per register.
// Optional feature macro: ARCH_DUMP_CHECKSUM_EN appends an XOR checksum beat.
module arch_reg_dump_unit
  import dump_pkg::*;
#(
  parameter int NUM_ARCH_REGS = DEF_NUM_ARCH_REGS,
  parameter int AREG_W        = DEF_AREG_W,
  parameter int PREG_W        = DEF_PREG_W,
  parameter int XLEN          = DEF_XLEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  output logic              stall_fetch,
  input  logic              rob_empty,
  output logic [AREG_W-1:0] map_rd_addr,
  input  logic [PREG_W-1:0] map_rd_data,
  output logic              prf_rd_en,
  output logic [PREG_W-1:0] prf_rd_addr,
  input  logic [XLEN-1:0]   prf_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [AREG_W-1:0] dump_areg,
  output logic [PREG_W-1:0] dump_preg,
  output logic [XLEN-1:0]   dump_data,
  output logic              dump_last,
  output logic              dump_done,
  output dump_state_e       state_dbg
);

  localparam logic [AREG_W-1:0] LAST_IDX = AREG_W'(NUM_ARCH_REGS - 1);

  dump_state_e       state, state_n;
  logic [AREG_W-1:0] idx;
  logic [PREG_W-1:0] preg_q;
  logic              is_last;
  logic              beat_hs;

  logic              ld_en;
  logic [AREG_W-1:0] ld_areg;
  logic [PREG_W-1:0] ld_preg;
  logic [XLEN-1:0]   ld_data;
  logic              ld_last;

`ifdef ARCH_DUMP_CHECKSUM_EN
  logic [XLEN-1:0]   csum_q;
`endif

  assign is_last   = (idx == LAST_IDX);
  assign beat_hs   = dump_valid && dump_ready;
  assign state_dbg = state;

  // State, walk index and the phys tag captured from the committed map.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      idx    <= '0;
      preg_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        idx <= '0;
      end else if (state == SEND && beat_hs && !is_last) begin
        idx <= idx + AREG_W'(1);
      end
      if (state == MAP) begin
        preg_q <= map_rd_data;
      end
    end
  end

`ifdef ARCH_DUMP_CHECKSUM_EN
  // Running XOR of every register value as it is loaded into the beat register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      csum_q <= '0;
    end else if (state == IDLE && req_valid) begin
      csum_q <= '0;
    end else if (state == READ) begin
      csum_q <= csum_q ^ ld_data;
    end
  end
`endif

  // Next-state decode and per-state strobes.
  always_comb begin
    state_n     = state;
    req_ready   = 1'b0;
    stall_fetch = 1'b1;
    map_rd_addr = '0;
    prf_rd_en   = 1'b0;
    prf_rd_addr = '0;
    dump_done   = 1'b0;
    ld_en       = 1'b0;
    ld_areg     = '0;
    ld_preg     = '0;
    ld_data     = '0;
    ld_last     = 1'b0;
    case (state)
      IDLE: begin
        req_ready   = 1'b1;
        stall_fetch = 1'b0;
        if (req_valid) state_n = DRAIN;
      end
      DRAIN: begin
        if (rob_empty) state_n = MAP;
      end
      MAP: begin
        map_rd_addr = idx;
        prf_rd_en   = 1'b1;
        prf_rd_addr = map_rd_data;
        state_n     = READ;
      end
      READ: begin
        // x0 is hardwired zero whatever the PRF holds for its tag.
        ld_en   = 1'b1;
        ld_areg = idx;
        ld_preg = preg_q;
        ld_data = (idx == '0) ? '0 : prf_rd_data;
`ifdef ARCH_DUMP_CHECKSUM_EN
        ld_last = 1'b0;
`else
        ld_last = is_last;
`endif
        state_n = SEND;
      end
      SEND: begin
        if (beat_hs) begin
          if (is_last) begin
`ifdef ARCH_DUMP_CHECKSUM_EN
            // Checksum beat replaces the departing x(N-1) beat directly.
            ld_en   = 1'b1;
            ld_data = csum_q;
            ld_last = 1'b1;
            state_n = CSUM;
`else
            state_n = DONE;
`endif
          end else begin
            state_n = MAP;
          end
        end
      end
`ifdef ARCH_DUMP_CHECKSUM_EN
      CSUM: begin
        if (beat_hs) state_n = DONE;
      end
`endif
      DONE: begin
        dump_done = 1'b1;
        state_n   = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  arch_dump_beat_reg #(
    .AREG_W (AREG_W),
    .PREG_W (PREG_W),
    .XLEN   (XLEN)
  ) u_beat (
    .clk       (clk),
    .reset     (reset),
    .load      (ld_en),
    .in_areg   (ld_areg),
    .in_preg   (ld_preg),
    .in_data   (ld_data),
    .in_last   (ld_last),
    .out_valid (dump_valid),
    .out_ready (dump_ready),
    .out_areg  (dump_areg),
    .out_preg  (dump_preg),
    .out_data  (dump_data),
    .out_last  (dump_last)
  );

endmodule
